wb_counter_ctrl: RTL and testbench

Wishbone-mapped controller that configures and sequences the user-area BITS-wide counter datapath. It owns the counter's enable, load and compare/interrupt logic. It arbitrates load requests between the Wishbone bus and the logic-analyzer (LA) override path. It sits between the user-project-wrapper bus/LA pins and the counter, which keeps only the count register and step adder.

---
 rtl/wb_counter_ctrl_if.sv | 21 ++
 rtl/wb_counter_ctrl.sv | 156 +++++++++++++++
 tb/tb_wb_counter_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_counter_ctrl_if.sv
// rtl/wb_counter_ctrl_if.sv - Wishbone classic slave bus bundle for wb_counter_ctrl
interface wb_counter_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_counter_ctrl.sv
// rtl/wb_counter_ctrl.sv - Wishbone-mapped enable/load/compare controller for the user counter
module wb_counter_ctrl #(
  parameter int          BITS     = 30,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_counter_ctrl_if.slave wbs,
  input  logic            la_load_req,
  input  logic [BITS-1:0] la_load_val,
  input  logic [BITS-1:0] cnt_value,
  output logic            cnt_en,
  output logic            cnt_load,
  output logic [BITS-1:0] cnt_load_val,
  output logic            irq
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} bus_state_t;

  bus_state_t      state, state_next;
  logic            bus_hit, bus_take, wr;
  logic [2:0]      reg_idx;
  logic [31:0]     wr_mask;
  logic [31:0]     rd_data, dat_q;
  logic [31:0]     load_ext, compare_ext, count_ext;
  logic [31:0]     load_merged, compare_merged, ctrl_merged;

  logic            ctrl_en, ctrl_oneshot, ctrl_irq_en;
  logic [BITS-1:0] load_reg, compare_reg;
  logic            match, load_pend;
  logic            match_hit, status_w1c, load_wr, wb_issue;
  logic            unused_bits;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [31:0] m);
    return (old & ~m) | (dat & m);
  endfunction

  assign bus_hit = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign reg_idx = wbs.wbs_adr_i[4:2];
  assign wr      = bus_take & wbs.wbs_we_i;
  assign wr_mask = {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}},
                    {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};

  // Zero-extend BITS-wide state to the 32-bit bus width
  always_comb begin
    load_ext                = '0;
    compare_ext             = '0;
    count_ext               = '0;
    load_ext[BITS-1:0]      = load_reg;
    compare_ext[BITS-1:0]   = compare_reg;
    count_ext[BITS-1:0]     = cnt_value;
  end

  assign load_merged    = merge(load_ext, wbs.wbs_dat_i, wr_mask);
  assign compare_merged = merge(compare_ext, wbs.wbs_dat_i, wr_mask);
  assign ctrl_merged    = merge({29'b0, ctrl_irq_en, ctrl_oneshot, ctrl_en}, wbs.wbs_dat_i, wr_mask);

  assign match_hit  = ctrl_en & (cnt_value == compare_reg);
  assign status_w1c = wr & (reg_idx == 3'd3) & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[0];
  assign load_wr    = wr & (reg_idx == 3'd1);
  // A fresh LOAD write defers issue by one cycle so only the newest value is loaded
  assign wb_issue   = load_pend & ~la_load_req & ~load_wr;

  assign unused_bits = ^{wbs.wbs_adr_i[7:5], wbs.wbs_adr_i[1:0], load_merged,
                         compare_merged, ctrl_merged};

  // Bus state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Bus next-state: accept a hit in IDLE, always return from ACK
  always_comb begin
    state_next = state;
    bus_take   = 1'b0;
    case (state)
      ST_IDLE: if (bus_hit) begin
        state_next = ST_ACK;
        bus_take   = 1'b1;
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Register read mux
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      3'd0:    rd_data = {29'b0, ctrl_irq_en, ctrl_oneshot, ctrl_en};
      3'd1:    rd_data = load_ext;
      3'd2:    rd_data = compare_ext;
      3'd3:    rd_data = {30'b0, load_pend, match};
      3'd4:    rd_data = count_ext;
      default: rd_data = '0;
    endcase
  end

  // Read data is captured with the request and held only for the ack cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                     dat_q <= '0;
    else if (bus_take & ~wbs.wbs_we_i) dat_q <= rd_data;
    else                              dat_q <= '0;
  end

  assign wbs.wbs_ack_o = (state == ST_ACK);
  assign wbs.wbs_dat_o = dat_q;

  // Config registers, sticky match and one-shot auto-disable
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl_en      <= 1'b0;
      ctrl_oneshot <= 1'b0;
      ctrl_irq_en  <= 1'b0;
      load_reg     <= '0;
      compare_reg  <= '1;
      match        <= 1'b0;
    end else begin
      if (wr && reg_idx == 3'd0) begin
        ctrl_en      <= ctrl_merged[0];
        ctrl_oneshot <= ctrl_merged[1];
        ctrl_irq_en  <= ctrl_merged[2];
      end
      if (match_hit && ctrl_oneshot) ctrl_en <= 1'b0;
      if (load_wr) load_reg <= load_merged[BITS-1:0];
      if (wr && reg_idx == 3'd2) compare_reg <= compare_merged[BITS-1:0];
      match <= match_hit | (match & ~status_w1c);
    end
  end

  // Load arbitration: LA first, bus load held pending until LA is idle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      load_pend    <= 1'b0;
      cnt_load     <= 1'b0;
      cnt_load_val <= '0;
    end else begin
      cnt_load <= la_load_req | wb_issue;
      if (la_load_req)   cnt_load_val <= la_load_val;
      else if (wb_issue) cnt_load_val <= load_reg;
      if (load_wr)       load_pend <= 1'b1;
      else if (wb_issue) load_pend <= 1'b0;
    end
  end

  // Registered interrupt level
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq <= 1'b0;
    else          irq <= match & ctrl_irq_en;
  end

  assign cnt_en = ctrl_en;

endmodule

// File: tb/tb_wb_counter_ctrl.sv
// tb/tb_wb_counter_ctrl.sv - self-checking bench for wb_counter_ctrl
module tb_wb_counter_ctrl;
  localparam int          BITS = 30;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] MASK = 32'h3FFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            la_load_req;
  logic [BITS-1:0] la_load_val;
  logic [BITS-1:0] cnt_value;
  logic            cnt_en, cnt_load, irq;
  logic [BITS-1:0] cnt_load_val;

  wb_counter_ctrl_if bus ();

  wb_counter_ctrl #(.BITS(BITS), .BASE_ADR(BASE)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs          (bus),
    .la_load_req  (la_load_req),
    .la_load_val  (la_load_val),
    .cnt_value    (cnt_value),
    .cnt_en       (cnt_en),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .irq          (irq)
  );

  // Counter datapath stand-in, with an override for forcing compare values
  logic [BITS-1:0] cnt_model = '0;
  bit              ovr_en = 1'b0;
  logic [BITS-1:0] ovr_val = '0;
  always @(posedge clk) begin
    if (cnt_load)    cnt_model <= cnt_load_val;
    else if (cnt_en) cnt_model <= cnt_model + 1'b1;
  end
  assign cnt_value = ovr_en ? ovr_val : cnt_model;

  int n_tests = 0;
  int n_fail  = 0;

  // Register-file reference model: contents and writable bits per offset
  logic [31:0] m_reg   [8];
  logic [31:0] m_wmask [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
    m_reg[2] = MASK;
  endtask

  task automatic model_write(input int off, input logic [31:0] dat, input logic [3:0] sel);
    for (int b = 0; b < 4; b++)
      if (sel[b]) m_reg[off][8*b +: 8] = dat[8*b +: 8];
    m_reg[off] = m_reg[off] & m_wmask[off];
  endtask

  task automatic bus_access(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output logic [31:0] rdata, output bit acked);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    acked = 1'b0;
    rdata = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.wbs_ack_o) begin
        acked = 1'b1;
        rdata = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    if (acked) begin
      step();
      check("ack_one_cycle", {31'b0, bus.wbs_ack_o}, 32'h0);
    end
  endtask

  task automatic wb_write(input int off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd;
    bit          ak;
    bus_access(1'b1, BASE + 32'(off * 4), dat, sel, rd, ak);
    check("wr_ack", {31'b0, ak}, 32'h1);
  endtask

  task automatic wb_read(input int off, output logic [31:0] rd);
    bit ak;
    bus_access(1'b0, BASE + 32'(off * 4), 32'h0, 4'hF, rd, ak);
    check("rd_ack", {31'b0, ak}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    bit          ak;
    bit          found;
    int          off;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          live [5];

    m_wmask = '{32'h7, MASK, MASK, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    model_reset();
    live = '{1, 2, 5, 6, 7};

    rst = 1'b1;
    la_load_req = 1'b0;
    la_load_val = '0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    repeat (3) step();

    // Reset values
    check("rst_ack", {31'b0, bus.wbs_ack_o}, 32'h0);
    check("rst_dat", bus.wbs_dat_o, 32'h0);
    check("rst_outs", {28'b0, cnt_en, cnt_load, |cnt_load_val, irq}, 32'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      wb_read(i, rd);
      check($sformatf("rst_reg%0d", i), rd, m_reg[i]);
    end
    bus_access(1'b0, BASE + 32'h100, 32'h0, 4'hF, rd, ak);
    check("miss_noack", {31'b0, ak}, 32'h0);

    // Byte-lane LOAD writes, each followed by one load pulse
    wb_write(1, 32'h123, 4'b0001);
    model_write(1, 32'h123, 4'b0001);
    check("ld1_pulse", {31'b0, cnt_load}, 32'h1);
    check("ld1_val", 32'(cnt_load_val), m_reg[1]);
    step();
    check("ld1_single", {31'b0, cnt_load}, 32'h0);
    wb_read(1, rd);
    check("ld1_read", rd, 32'h23);

    wb_write(1, 32'h0000_0456, 4'b1111);
    model_write(1, 32'h0000_0456, 4'b1111);
    check("ld2_pulse", {31'b0, cnt_load}, 32'h1);
    check("ld2_val", 32'(cnt_load_val), 32'h456);
    step();
    check("ld2_single", {31'b0, cnt_load}, 32'h0);
    wb_read(1, rd);
    check("ld2_read", rd, 32'h456);

    // LA override holds off a bus load without losing it
    la_load_req = 1'b1;
    la_load_val = BITS'(32'h77);
    for (int i = 0; i < 5; i++) begin
      step();
      check("la_load", {31'b0, cnt_load}, 32'h1);
      check("la_val", 32'(cnt_load_val), 32'h77);
      if (i == 0) begin
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_adr_i = BASE + 32'h4; bus.wbs_dat_i = 32'h10; bus.wbs_sel_i = 4'hF;
      end
      if (i == 1) begin
        check("la_wr_ack", {31'b0, bus.wbs_ack_o}, 32'h1);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      end
      if (i == 2) begin
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = BASE + 32'hC;
      end
      if (i == 3) begin
        check("la_rd_ack", {31'b0, bus.wbs_ack_o}, 32'h1);
        check("la_pend", bus.wbs_dat_o, 32'h2);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      end
    end
    model_write(1, 32'h10, 4'hF);
    la_load_req = 1'b0;
    step();
    check("la_after_load", {31'b0, cnt_load}, 32'h1);
    check("la_after_val", 32'(cnt_load_val), m_reg[1]);
    step();
    check("la_after_single", {31'b0, cnt_load}, 32'h0);
    wb_read(3, rd);
    check("la_pend_clear", rd, 32'h0);

    // One-shot compare with interrupt
    wb_write(2, 32'h5, 4'hF);
    model_write(2, 32'h5, 4'hF);
    wb_write(1, 32'h0, 4'hF);
    model_write(1, 32'h0, 4'hF);
    step();
    wb_write(0, 32'h7, 4'hF);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (cnt_value == BITS'(5)) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("os_reach", {31'b0, found}, 32'h1);
    check("os_en_before", {31'b0, cnt_en}, 32'h1);
    step();
    check("os_en_after", {31'b0, cnt_en}, 32'h0);
    check("os_irq_lag", {31'b0, irq}, 32'h0);
    step();
    check("os_irq", {31'b0, irq}, 32'h1);
    wb_read(3, rd);
    check("os_match", rd, 32'h1);
    wb_read(0, rd);
    check("os_ctrl", rd, 32'h6);
    wb_write(3, 32'h1, 4'hF);
    check("os_irq_clear", {31'b0, irq}, 32'h0);
    wb_read(3, rd);
    check("os_status_clear", rd, 32'h0);

    // Continuous mode: a live match beats a same-cycle clear
    ovr_en  = 1'b1;
    ovr_val = BITS'(5);
    wb_write(0, 32'h1, 4'hF);
    wb_write(3, 32'h1, 4'hF);
    wb_read(3, rd);
    check("cont_match_wins", rd, 32'h1);
    check("cont_en", {31'b0, cnt_en}, 32'h1);
    ovr_val = BITS'(9);
    wb_write(3, 32'h1, 4'hF);
    wb_read(3, rd);
    check("cont_w1c", rd, 32'h0);
    wb_write(0, 32'h0, 4'hF);
    ovr_en = 1'b0;

    // Reset while in ACK with a load pending behind the LA path
    la_load_req = 1'b1;
    la_load_val = BITS'(32'h55);
    wb_write(1, 32'hAA, 4'hF);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = BASE;
    step();
    check("rst_mid_ack", {31'b0, bus.wbs_ack_o}, 32'h1);
    rst = 1'b1;
    la_load_req = 1'b0;
    step();
    check("rst_mid_ack_off", {31'b0, bus.wbs_ack_o}, 32'h0);
    check("rst_mid_dat", bus.wbs_dat_o, 32'h0);
    check("rst_mid_outs", {28'b0, cnt_en, cnt_load, |cnt_load_val, irq}, 32'h0);
    step();
    check("rst_mid_hold", {31'b0, bus.wbs_ack_o}, 32'h0);
    rst = 1'b0;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    model_reset();
    step();
    check("rst_drop_load0", {31'b0, cnt_load}, 32'h0);
    step();
    check("rst_drop_load1", {31'b0, cnt_load}, 32'h0);
    wb_read(1, rd);
    check("rst_load_reg", rd, 32'h0);
    wb_read(3, rd);
    check("rst_status", rd, 32'h0);

    // Randomized register traffic against the model
    wb_write(1, 32'h0, 4'hF);
    model_write(1, 32'h0, 4'hF);
    step();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        off = live[$urandom_range(0, 4)];
        dat = $urandom;
        sel = 4'($urandom_range(1, 15));
        wb_write(off, dat, sel);
        model_write(off, dat, sel);
        if (off == 1) begin
          check("rnd_ld_pulse", {31'b0, cnt_load}, 32'h1);
          check("rnd_ld_val", 32'(cnt_load_val), m_reg[1]);
        end
        step();
      end else begin
        off = $urandom_range(0, 7);
        wb_read(off, rd);
        if (off == 4) check("rnd_count", rd, m_reg[1]);
        else          check($sformatf("rnd_reg%0d", off), rd, m_reg[off]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
